// File: rtl/norg_pkg.sv
// Shared constants and helpers for the NOR gate with registered edge/toggle
// tracking and input-combination coverage.
package norg_pkg;

    localparam int CNT_W_DEF = 8;

    localparam logic [1:0] COV_00 = 2'd0;
    localparam logic [1:0] COV_01 = 2'd1;
    localparam logic [1:0] COV_10 = 2'd2;
    localparam logic [1:0] COV_11 = 2'd3;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_e;

    // Classify a transition from the current level to the next level.
    function automatic edge_e edge_kind(input logic prev, input logic next);
        edge_e k;
        case ({prev, next})
            2'b01:   k = EDGE_RISE;
            2'b10:   k = EDGE_FALL;
            default: k = EDGE_NONE;
        endcase
        return k;
    endfunction

    function automatic logic [1:0] ab_index(input logic a, input logic b);
        return {a, b};
    endfunction

endpackage

// File: rtl/norg_toggle_cnt.sv
// Registers Y, keeps a one-cycle-delayed copy, produces registered rise/fall
// pulses and a saturating count of Y_q transitions.
module norg_toggle_cnt
    import norg_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             y_i,
    output logic             y_q_o,
    output logic             y_rise_o,
    output logic             y_fall_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             y_q_q,  y_q_d;
    logic             dly_q,  dly_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    edge_e            edge_s;

    // Next-state: pulses are decoded from the values Y_q and its delayed copy
    // will hold after this edge, so each pulse lines up with the Y_q change.
    always_comb begin
        y_q_d  = y_i;
        dly_d  = y_q_q;
        edge_s = edge_kind(dly_d, y_q_d);
        rise_d = 1'b0;
        fall_d = 1'b0;
        case (edge_s)
            EDGE_RISE: rise_d = 1'b1;
            EDGE_FALL: fall_d = 1'b1;
            default: begin
                rise_d = 1'b0;
                fall_d = 1'b0;
            end
        endcase
        // Y_q differing from its delayed copy is exactly a pulse cycle.
        if ((y_q_q ^ dly_q) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers; reset level of Y_q and its copy is 1 (NOR of idle inputs).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            y_q_q  <= 1'b1;
            dly_q  <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            cnt_q  <= {CNT_W{1'b0}};
        end else begin
            y_q_q  <= y_q_d;
            dly_q  <= dly_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            cnt_q  <= cnt_d;
        end
    end

    assign y_q_o    = y_q_q;
    assign y_rise_o = rise_q;
    assign y_fall_o = fall_q;
    assign cnt_o    = cnt_q;

endmodule

// File: rtl/norg.sv
// NOR gate with a registered copy, edge pulses, a saturating toggle counter
// and sticky coverage of every sampled {A,B} combination.
module norg
    import norg_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             A,
    input  logic             B,
    output logic             Y,
    output logic             Y_q,
    output logic             y_rise,
    output logic             y_fall,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic [3:0]       cov,
    output logic             cov_all
);

    logic [3:0] cov_q, cov_d;

    assign Y = ~(A | B);

    norg_toggle_cnt #(
        .CNT_W (CNT_W)
    ) u_toggle (
        .clk_i    (clk),
        .rst_i    (rst),
        .y_i      (Y),
        .y_q_o    (Y_q),
        .y_rise_o (y_rise),
        .y_fall_o (y_fall),
        .cnt_o    (toggle_cnt)
    );

    // Mark the combination seen at this edge; earlier marks are kept.
    always_comb begin
        cov_d                 = cov_q;
        cov_d[ab_index(A, B)] = 1'b1;
    end

    // Sticky coverage register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cov_q <= 4'b0000;
        end else begin
            cov_q <= cov_d;
        end
    end

    assign cov     = cov_q;
    assign cov_all = cov_q[COV_00] & cov_q[COV_01] & cov_q[COV_10] & cov_q[COV_11];

endmodule

// File: tb/tb_norg.sv
// Directed bench for norg: expected register state is queued per clocked step
// and compared by a separate negedge monitor; combinational and async-reset
// behaviour is checked directly at the instant it must hold.
module tb_norg;

    logic       clk;
    logic       clk_en;
    logic       rst;
    logic       A, B;
    logic       Y, Y_q, y_rise, y_fall, cov_all;
    logic [7:0] toggle_cnt;
    logic [3:0] cov;

    logic       s_Y, s_Y_q, s_rise, s_fall, s_cov_all;
    logic [1:0] s_cnt;
    logic [3:0] s_cov;

    int checks;
    int errors;

    typedef struct {
        logic       yq;
        logic       rise;
        logic       fall;
        int         cnt;
        logic [3:0] cov;
        logic       cov_all;
    } exp_t;

    exp_t sb_q[$];

    norg #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .Y(Y), .Y_q(Y_q),
        .y_rise(y_rise), .y_fall(y_fall), .toggle_cnt(toggle_cnt),
        .cov(cov), .cov_all(cov_all)
    );

    norg #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .A(A), .B(B), .Y(s_Y), .Y_q(s_Y_q),
        .y_rise(s_rise), .y_fall(s_fall), .toggle_cnt(s_cnt),
        .cov(s_cov), .cov_all(s_cov_all)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: one queued expectation per clocked step.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            int   sat;
            e   = sb_q.pop_front();
            sat = (e.cnt > 3) ? 3 : e.cnt;
            chk("Y_q",        int'(Y_q),        int'(e.yq));
            chk("y_rise",     int'(y_rise),     int'(e.rise));
            chk("y_fall",     int'(y_fall),     int'(e.fall));
            chk("toggle_cnt", int'(toggle_cnt), e.cnt);
            chk("cov",        int'(cov),        int'(e.cov));
            chk("cov_all",    int'(cov_all),    int'(e.cov_all));
            chk("sat_cnt",    int'(s_cnt),      sat);
            chk("sat_Y_q",    int'(s_Y_q),      int'(e.yq));
        end
    end

    // Called at a negedge: drive inputs, let one edge pass, queue expectation.
    task automatic step(input logic a, input logic b, input logic yq,
                        input logic r, input logic f, input int cnt,
                        input logic [3:0] cv, input logic ca);
        exp_t e;
        A = a;
        B = b;
        @(posedge clk);
        #1;
        e.yq = yq; e.rise = r; e.fall = f; e.cnt = cnt; e.cov = cv; e.cov_all = ca;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    // Brief input excursion between edges; only Y may react.
    task automatic glitch(input logic ga, input logic gb, input logic gy,
                          input logic oa, input logic ob, input logic oy);
        A = ga; B = gb;
        #1 chk("glitch_Y", int'(Y), int'(gy));
        A = oa; B = ob;
        #1 chk("glitch_Y_back", int'(Y), int'(oy));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk_en = 1'b0;
        rst    = 1'b1;
        A      = 1'b0;
        B      = 1'b0;

        // Clockless sweep with reset held: Y must follow the inputs directly.
        #5 chk("Y_00", int'(Y), 1);
        A = 1'b0; B = 1'b1;
        #5 chk("Y_01", int'(Y), 0);
        A = 1'b1; B = 1'b0;
        #5 chk("Y_10", int'(Y), 0);
        A = 1'b1; B = 1'b1;
        #5 chk("Y_11", int'(Y), 0);
        A = 1'b0; B = 1'b0;
        #5 chk("Y_00_again", int'(Y), 1);

        chk("rst_Y_q",     int'(Y_q),        1);
        chk("rst_y_rise",  int'(y_rise),     0);
        chk("rst_y_fall",  int'(y_fall),     0);
        chk("rst_cnt",     int'(toggle_cnt), 0);
        chk("rst_cov",     int'(cov),        0);
        chk("rst_cov_all", int'(cov_all),    0);

        clk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        //    A     B     Y_q   rise  fall  cnt cov      cov_all
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 4'b0001, 1'b0);
        glitch(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 4'b0001, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 4'b0101, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 4'b0101, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 4'b0111, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 4'b1111, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 4'b1111, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 4'b1111, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3, 4'b1111, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4, 4'b1111, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5, 4'b1111, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6, 4'b1111, 1'b1);
        glitch(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6, 4'b1111, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6, 4'b1111, 1'b1);

        // Asynchronous reset between edges, with Y_q low and a pulse pending.
        #2 rst = 1'b1;
        #1;
        chk("arst_Y_q",    int'(Y_q),        1);
        chk("arst_y_fall", int'(y_fall),     0);
        chk("arst_cnt",    int'(toggle_cnt), 0);
        chk("arst_cov",    int'(cov),        0);
        chk("arst_cov_all",int'(cov_all),    0);
        chk("arst_sat_cnt",int'(s_cnt),      0);
        chk("arst_Y",      int'(Y),          0);

        @(negedge clk);
        A = 1'b0; B = 1'b0;
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 4'b0001, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 4'b0101, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 4'b0101, 1'b0);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/norg.md
NORG -- requirements
Module: norg

Interface
REQ-001 Parameter CNT_W, default 8, width of the Y-toggle counter, legal range 2..32.
REQ-002 clk  input  1  single clock; all sequential logic on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 A  input  1  NOR operand A.
REQ-005 B  input  1  NOR operand B.
REQ-006 Y  output  1  combinational NOR of A and B.
REQ-007 Y_q  output  1  Y registered once on clk.
REQ-008 y_rise  output  1  one-cycle pulse when Y_q goes 0->1.
REQ-009 y_fall  output  1  one-cycle pulse when Y_q goes 1->0.
REQ-010 toggle_cnt  output  CNT_W  saturating count of Y_q transitions.
REQ-011 cov  output  4  sticky flags, one per sampled {A,B} combination; bit index = {A,B}.
REQ-012 cov_all  output  1  high when all four cov bits are set.

Function
REQ-013 Y SHALL equal ~(A|B) at all times: 00->1, 01->0, 10->0, 11->0; zero cycle latency; independent of clk and rst.
REQ-014 Y SHALL respond to every A/B change without a clock, so a clockless bench sees correct Y.
REQ-015 Y_q SHALL take the value of Y at each rising clk edge: one-cycle latency.
REQ-016 y_rise/y_fall SHALL be computed from Y_q and its one-cycle-delayed copy; each SHALL be registered, high for exactly one cycle, and never both high together.
REQ-017 toggle_cnt SHALL increment by 1 on each cycle where y_rise or y_fall is asserted.
REQ-018 toggle_cnt SHALL saturate at 2^CNT_W-1 and hold; it SHALL never wrap.
REQ-019 At each rising edge, cov[{A,B}] SHALL be set; set bits remain set until reset.
REQ-020 cov_all SHALL be combinational AND of cov[3:0].
REQ-021 A/B changes between clock edges SHALL affect Y only; registered outputs see only edge-sampled values.

Reset
REQ-022 While rst is high, the following SHALL be forced immediately, without waiting for a clock edge: Y_q=1, delayed copy=1, y_rise=0, y_fall=0, toggle_cnt=0, cov=4'b0000.
REQ-023 Y SHALL be unaffected by rst.
REQ-024 Reset asserted mid-count SHALL clear all state immediately.
REQ-025 The first edge after rst release SHALL sample normally; no spurious y_rise/y_fall SHALL be generated unless Y differs from the reset value 1.

Structure
REQ-026 Package norg_pkg SHALL hold the CNT_W default constant and the cov bit-index constants COV_00, COV_01, COV_10, COV_11.
REQ-027 One sub-module, norg_toggle_cnt, SHALL contain the Y_q delay, the edge detectors and the saturating counter; the NOR and the coverage flags stay in norg.

Verification
REQ-028 Sweep {A,B} = 00,01,10,11 at 5-time-unit steps with no clock -> Y = 1,0,0,0, each correct immediately after the change.
REQ-029 Reset, then clocked A=0,B=0 then A=1,B=0 -> Y_q 1 then 0, y_fall one cycle, toggle_cnt=1.
REQ-030 CNT_W=2; alternate A each cycle for 6 cycles -> toggle_cnt reaches 3 and holds.
REQ-031 Apply all four {A,B} combinations, one per clock -> cov=4'b1111, cov_all=1; assert rst between clock edges -> cov=0, toggle_cnt=0 immediately.
REQ-032 Change A/B and return it before the next edge (glitch) -> Y follows the change; Y_q, cov and toggle_cnt unchanged.
